// File: rtl/bp_common_pkg.sv
// Shared definitions for the stall-attribution profiler: counter index map
// and the dump FSM state type.
package bp_common_pkg;

  // Dump port walks the counters in index order while in e_dump.
  typedef enum logic {
    e_idle = 1'b0,
    e_dump = 1'b1
  } dump_state_e;

  // Counter map: reasons occupy 0..R-1, followed by three summary counters.
  function automatic int commit_idx(input int num_reasons);
    return num_reasons;
  endfunction

  function automatic int bubble_idx(input int num_reasons);
    return num_reasons + 1;
  endfunction

  function automatic int total_idx(input int num_reasons);
    return num_reasons + 2;
  endfunction

  function automatic int num_ctrs(input int num_reasons);
    return num_reasons + 3;
  endfunction

endpackage

// File: rtl/bp_core_stall_counters_if.sv
// Counter dump port: request handshake, one beat per counter, done pulse.
interface bp_core_stall_counters_if #(
  parameter int num_reasons_p = 16,
  parameter int ctr_width_p   = 32
);
  localparam int idx_width_lp = $clog2(num_reasons_p + 3);

  logic                    dump_v_i;
  logic                    dump_ready_o;
  logic                    data_v_o;
  logic [idx_width_lp-1:0] data_idx_o;
  logic [ctr_width_p-1:0]  data_o;
  logic                    data_ready_i;
  logic                    dump_done_o;

  // Profiler side.
  modport slave (
    input  dump_v_i, data_ready_i,
    output dump_ready_o, data_v_o, data_idx_o, data_o, dump_done_o
  );

  // Consumer side.
  modport master (
    output dump_v_i, data_ready_i,
    input  dump_ready_o, data_v_o, data_idx_o, data_o, dump_done_o
  );
endinterface

// File: rtl/bp_stall_attrib_pipe.sv
// Shadow pipe that carries stall reasons alongside the real pipeline. Each
// stage ORs in the reasons its mask admits, so a reason raised at stage s
// reaches the retire slot S-s cycles later.
module bp_stall_attrib_pipe #(
  parameter int num_reasons_p = 16,
  parameter int num_stages_p  = 8,
  parameter logic [num_stages_p*num_reasons_p-1:0] stage_mask_p = '1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [num_reasons_p-1:0] events_i,
  output logic [num_reasons_p-1:0] reasons_o
);

  logic [num_reasons_p-1:0] stage_r [num_stages_p];
  logic [num_reasons_p-1:0] stage_n [num_stages_p];

  // Next-state of every stage: previous stage plus this cycle's masked events.
  always_comb begin
    stage_n[0] = events_i & stage_mask_p[0 +: num_reasons_p];
    for (int s = 1; s < num_stages_p; s++) begin
      stage_n[s] = stage_r[s-1] | (events_i & stage_mask_p[s*num_reasons_p +: num_reasons_p]);
    end
  end

  // Shift the whole pipe every cycle; counting enable does not gate it.
  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour; blocking here would collapse the pipe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < num_stages_p; s++) stage_r[s] <= '0;
    end else begin
      for (int s = 0; s < num_stages_p; s++) stage_r[s] <= stage_n[s];
    end
  end

  assign reasons_o = stage_r[num_stages_p-1];

endmodule

// File: rtl/bp_core_stall_counters.sv
// Stall-attribution profiler: classifies each retire-slot cycle as commit,
// stall reason(s) or bubble, keeps saturating counters, and streams them out
// over the dump port. Purely observational.
module bp_core_stall_counters
  import bp_common_pkg::*;
#(
  parameter int num_reasons_p   = 16,
  parameter int num_stages_p    = 8,
  parameter int ctr_width_p     = 32,
  parameter logic [num_stages_p*num_reasons_p-1:0] stage_mask_p = '1,
  parameter bit multi_attr_p    = 1'b0,
  parameter bit clear_on_dump_p = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [num_reasons_p-1:0] events_i,
  input  logic                     commit_v_i,
  bp_core_stall_counters_if.slave  dump_if
);

  localparam int num_ctrs_lp  = num_ctrs(num_reasons_p);
  localparam int idx_width_lp = $clog2(num_ctrs_lp);
  localparam int commit_lp    = commit_idx(num_reasons_p);
  localparam int bubble_lp    = bubble_idx(num_reasons_p);
  localparam int total_lp     = total_idx(num_reasons_p);
  localparam logic [ctr_width_p-1:0] ctr_max_lp = '1;

  logic [num_reasons_p-1:0] reasons;
  logic [num_reasons_p-1:0] lowest_reason;
  logic [num_ctrs_lp-1:0]   inc;
  logic [ctr_width_p-1:0]   cnt_r [num_ctrs_lp];
  dump_state_e              state_r;
  logic [idx_width_lp-1:0]  idx_r;
  logic                     done_r;
  logic                     accept_beat;
  logic                     last_beat;

  bp_stall_attrib_pipe #(
    .num_reasons_p (num_reasons_p),
    .num_stages_p  (num_stages_p),
    .stage_mask_p  (stage_mask_p)
  ) pipe (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .events_i  (events_i),
    .reasons_o (reasons)
  );

  // Two's-complement trick isolates the lowest set reason bit.
  assign lowest_reason = reasons & (-reasons);

  // Per-counter increment strobes for this retire-slot cycle.
  always_comb begin
    inc = '0;
    if (en_i) begin
      inc[total_lp] = 1'b1;
      if (commit_v_i) begin
        inc[commit_lp] = 1'b1;
      end else if (|reasons) begin
        inc[num_reasons_p-1:0] = multi_attr_p ? reasons : lowest_reason;
      end else begin
        inc[bubble_lp] = 1'b1;
      end
    end
  end

  assign accept_beat = (state_r == e_dump) && dump_if.data_ready_i;
  assign last_beat   = (idx_r == idx_width_lp'(total_lp));

  // Dump FSM: walk idx 0..R+2, one beat per accepted data_ready_i.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_idle;
      idx_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= accept_beat && last_beat;
      case (state_r)
        e_idle: begin
          if (dump_if.dump_v_i) begin
            state_r <= e_dump;
            idx_r   <= '0;
          end
        end
        e_dump: begin
          if (accept_beat) begin
            if (last_beat) begin
              state_r <= e_idle;
              idx_r   <= '0;
            end else begin
              idx_r <= idx_r + idx_width_lp'(1);
            end
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  // Saturating counters; a read-cleared counter restarts from this cycle's increment.
  // NOTE: the counter bank is an array of flops, not a RAM, so it takes the
  // async reset like any other state; a RAM macro would need a clear sweep instead.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_ctrs_lp; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < num_ctrs_lp; i++) begin
        if (clear_on_dump_p && accept_beat && (idx_r == idx_width_lp'(i))) begin
          cnt_r[i] <= ctr_width_p'(inc[i]);
        end else if (inc[i] && (cnt_r[i] != ctr_max_lp)) begin
          cnt_r[i] <= cnt_r[i] + ctr_width_p'(1);
        end
      end
    end
  end

  assign dump_if.dump_ready_o = (state_r == e_idle);
  assign dump_if.data_v_o     = (state_r == e_dump);
  assign dump_if.data_idx_o   = idx_r;
  assign dump_if.data_o       = (state_r == e_dump) ? cnt_r[idx_r] : '0;
  assign dump_if.dump_done_o  = done_r;

endmodule

// File: tb/tb_bp_core_stall_counters.sv
// Directed bench: three profiler instances share the reason stream but have
// private enables, commits and dump ports, so latency, attribution mode and
// saturation can be compared side by side.
module tb_bp_core_stall_counters;

  localparam int R  = 16;
  localparam int S  = 8;
  localparam int NC = R + 3;
  // Reasons enter at stage 0 only, so one strobe retires exactly once.
  localparam logic [S*R-1:0] MASK0 = {{((S-1)*R){1'b0}}, {R{1'b1}}};

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   en, cm, dv, dr;
  logic [R-1:0] ev;
  int           sel;
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  got     [NC];
  logic [31:0]  exp_c   [NC];
  logic         m_ready, m_v, m_done;
  logic [31:0]  m_idx, m_data;

  always #5 clk = ~clk;

  bp_core_stall_counters_if #(.num_reasons_p(R), .ctr_width_p(32)) if_a ();
  bp_core_stall_counters_if #(.num_reasons_p(R), .ctr_width_p(32)) if_b ();
  bp_core_stall_counters_if #(.num_reasons_p(R), .ctr_width_p(4))  if_c ();

  assign if_a.dump_v_i = dv[0];  assign if_a.data_ready_i = dr[0];
  assign if_b.dump_v_i = dv[1];  assign if_b.data_ready_i = dr[1];
  assign if_c.dump_v_i = dv[2];  assign if_c.data_ready_i = dr[2];

  bp_core_stall_counters #(.num_reasons_p(R), .num_stages_p(S), .ctr_width_p(32),
    .stage_mask_p(MASK0), .multi_attr_p(1'b0), .clear_on_dump_p(1'b1)) dut_a (
    .clk_i(clk), .reset_i(rst), .en_i(en[0]), .events_i(ev), .commit_v_i(cm[0]), .dump_if(if_a));

  bp_core_stall_counters #(.num_reasons_p(R), .num_stages_p(S), .ctr_width_p(32),
    .stage_mask_p(MASK0), .multi_attr_p(1'b1), .clear_on_dump_p(1'b1)) dut_b (
    .clk_i(clk), .reset_i(rst), .en_i(en[1]), .events_i(ev), .commit_v_i(cm[1]), .dump_if(if_b));

  bp_core_stall_counters #(.num_reasons_p(R), .num_stages_p(S), .ctr_width_p(4),
    .stage_mask_p(MASK0), .multi_attr_p(1'b0), .clear_on_dump_p(1'b1)) dut_c (
    .clk_i(clk), .reset_i(rst), .en_i(en[2]), .events_i(ev), .commit_v_i(cm[2]), .dump_if(if_c));

  // Observe the selected instance's dump port.
  always_comb begin
    m_ready = if_a.dump_ready_o; m_v = if_a.data_v_o; m_done = if_a.dump_done_o;
    m_idx = 32'(if_a.data_idx_o); m_data = if_a.data_o;
    case (sel)
      1: begin
        m_ready = if_b.dump_ready_o; m_v = if_b.data_v_o; m_done = if_b.dump_done_o;
        m_idx = 32'(if_b.data_idx_o); m_data = if_b.data_o;
      end
      2: begin
        m_ready = if_c.dump_ready_o; m_v = if_c.data_v_o; m_done = if_c.dump_done_o;
        m_idx = 32'(if_c.data_idx_o); m_data = 32'(if_c.data_o);
      end
      default: ;
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; cm = '0; dv = '0; dr = '0; ev = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < NC; i++) exp_c[i] = 32'd0;
  endtask

  task automatic compare_ctrs(input string tag);
    for (int i = 0; i < NC; i++) check($sformatf("%s_ctr%0d", tag, i), got[i], exp_c[i]);
  endtask

  // Full dump of instance s; toggle=1 withholds data_ready_i on even cycles.
  task automatic dump(input int s, input bit toggle);
    int beats = 0;
    int guard = 0;
    bit rdy;
    sel = s;
    dv[s] = 1'b1;
    #1;
    check("dump_ready_idle", 32'(m_ready), 32'd1);
    cyc();
    dv[s] = 1'b0;
    while (beats < NC && guard < 100) begin
      rdy = toggle ? guard[0] : 1'b1;
      check("beat_valid", 32'(m_v), 32'd1);
      check("beat_idx", m_idx, 32'(beats));
      if (rdy) begin
        got[beats] = m_data;
        beats++;
      end
      dr[s] = rdy;
      cyc();
      dr[s] = 1'b0;
      guard++;
    end
    check("beat_count", 32'(beats), 32'(NC));
    check("done_pulse", 32'(m_done), 32'd1);
    check("valid_after_dump", 32'(m_v), 32'd0);
    check("ready_after_dump", 32'(m_ready), 32'd1);
    cyc();
    check("done_one_cycle", 32'(m_done), 32'd0);
  endtask

  initial begin
    sel = 0;
    rst = 1'b1; en = '0; cm = '0; dv = '0; dr = '0; ev = '0;
    cyc();
    check("rst_ready", 32'(m_ready), 32'd1);
    check("rst_valid", 32'(m_v), 32'd0);
    check("rst_idx", m_idx, 32'd0);
    check("rst_data", m_data, 32'd0);
    check("rst_done", 32'(m_done), 32'd0);

    // 1: ten idle counting cycles -> bubble and total only.
    do_reset();
    en = 3'b001;
    repeat (10) cyc();
    en = '0;
    dump(0, 1'b0);
    clear_exp(); exp_c[R+1] = 32'd10; exp_c[R+2] = 32'd10;
    compare_ctrs("idle");

    // 2: reason 3 retires exactly S cycles after injection; commit overrides it.
    do_reset();
    ev[3] = 1'b1; en = 3'b111;
    cyc();
    ev = '0;
    repeat (S - 1) cyc();
    en[0] = 1'b0; cm[2] = 1'b1;
    cyc();
    en = '0; cm = '0;
    dump(0, 1'b0);
    clear_exp(); exp_c[R+1] = 32'd8; exp_c[R+2] = 32'd8;
    compare_ctrs("lat_early");
    dump(1, 1'b0);
    clear_exp(); exp_c[3] = 32'd1; exp_c[R+1] = 32'd8; exp_c[R+2] = 32'd9;
    compare_ctrs("lat_exact");
    dump(2, 1'b0);
    clear_exp(); exp_c[R] = 32'd1; exp_c[R+1] = 32'd8; exp_c[R+2] = 32'd9;
    compare_ctrs("commit_wins");

    // 3: reasons 2 and 5 together, single vs multi attribution.
    do_reset();
    ev[2] = 1'b1; ev[5] = 1'b1; en = 3'b011;
    cyc();
    ev = '0;
    repeat (S) cyc();
    en = '0;
    dump(0, 1'b0);
    clear_exp(); exp_c[2] = 32'd1; exp_c[R+1] = 32'd8; exp_c[R+2] = 32'd9;
    compare_ctrs("single_attr");
    dump(1, 1'b0);
    clear_exp(); exp_c[2] = 32'd1; exp_c[5] = 32'd1; exp_c[R+1] = 32'd8; exp_c[R+2] = 32'd9;
    compare_ctrs("multi_attr");

    // 4: 4-bit counters saturate at 15.
    do_reset();
    ev[0] = 1'b1; en = 3'b100;
    repeat (20) cyc();
    ev = '0;
    repeat (10) cyc();
    en = '0;
    dump(2, 1'b0);
    clear_exp(); exp_c[0] = 32'd15; exp_c[R+1] = 32'd10; exp_c[R+2] = 32'd15;
    compare_ctrs("saturate");

    // 5: stalled dump while counting, then clear-on-read residue.
    do_reset();
    en = 3'b001;
    repeat (5) cyc();
    dump(0, 1'b1);
    en = '0;
    clear_exp(); exp_c[R+1] = 32'd41; exp_c[R+2] = 32'd43;
    compare_ctrs("live_dump");
    dump(0, 1'b0);
    clear_exp(); exp_c[R+1] = 32'd4; exp_c[R+2] = 32'd2;
    compare_ctrs("after_clear");

    // 6: asynchronous reset in the middle of a dump.
    do_reset();
    en = 3'b001;
    repeat (3) cyc();
    sel = 0;
    dv[0] = 1'b1;
    cyc();
    dv[0] = 1'b0; dr[0] = 1'b1;
    repeat (4) cyc();
    check("mid_dump_idx", m_idx, 32'd4);
    #2 rst = 1'b1;
    #1;
    check("async_ready", 32'(m_ready), 32'd1);
    check("async_valid", 32'(m_v), 32'd0);
    check("async_idx", m_idx, 32'd0);
    check("async_data", m_data, 32'd0);
    check("async_done", 32'(m_done), 32'd0);
    @(negedge clk);
    rst = 1'b0; dr = '0; en = '0;
    repeat (3) begin
      cyc();
      check("no_done_after_abort", 32'(m_done), 32'd0);
    end
    dump(0, 1'b0);
    clear_exp();
    compare_ctrs("post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
